lzw_dict_ram: RTL and testbench

Parametrised simple-dual-port dictionary memory for the LZW compressor. It is the successor to the single-port sync RAM: one write port and one read port, both usable in the same cycle.
- Each entry carries a per-entry valid bit, so the dictionary lookup can tell a real code from a stale one.
- A built-in clear sequencer invalidates the whole table after reset or on request, without the controller writing every address.
- Sits between the LZW match/encode FSM and the dictionary storage.

---
 rtl/lzw_pkg.sv | 19 +
 rtl/lzw_dict_ram_if.sv | 29 ++
 rtl/sdp_ram_core.sv | 24 ++
 rtl/lzw_dict_ram.sv | 150 +++++++++++++++
 tb/tb_lzw_dict_ram.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/lzw_pkg.sv
// Shared types and default sizes for the LZW dictionary storage.
package lzw_pkg;

  localparam int unsigned LZW_ADDR_W = 12;
  localparam int unsigned LZW_DATA_W = 20;
  localparam int unsigned LZW_CHAR_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } dict_state_e;

  // One dictionary entry: code of the prefix string plus the appended byte.
  typedef struct packed {
    logic [LZW_ADDR_W-1:0] prefix;
    logic [LZW_CHAR_W-1:0] chr;
  } dict_entry_t;

endpackage

// File: rtl/lzw_dict_ram_if.sv
// Request/response bundle between the LZW match FSM (master) and the dictionary (slave).
interface lzw_dict_ram_if #(
  parameter int unsigned ADDR_WIDTH = lzw_pkg::LZW_ADDR_W,
  parameter int unsigned DATA_WIDTH = lzw_pkg::LZW_DATA_W
);

  logic                  clear_req;
  logic                  busy;
  logic                  clear_done;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output clear_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  busy, clear_done, rd_valid, rd_hit, rd_data
  );

  modport slave (
    input  clear_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output busy, clear_done, rd_valid, rd_hit, rd_data
  );

endinterface

// File: rtl/sdp_ram_core.sv
// Simple-dual-port synchronous RAM: one write port, one registered read port, no reset.
module sdp_ram_core #(
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Callers guarantee addresses are below DEPTH.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lzw_dict_ram.sv
// LZW dictionary: data + per-entry valid columns, clear sweeper, write-first bypass,
// optional output register.
module lzw_dict_ram
  import lzw_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = LZW_ADDR_W,
  parameter int unsigned DATA_WIDTH = LZW_DATA_W,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  lzw_dict_ram_if.slave bus
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

  dict_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic                  busy_q, clear_done_q;

  logic                  idle, sweeping;
  logic                  wr_acc, rd_acc, rd_inr, byp;

  logic                  vld_we;
  logic [IW-1:0]         vld_waddr;
  logic [0:0]            vld_wdata, vld_rdata;
  logic [DATA_WIDTH-1:0] data_rdata;

  logic                  s1_valid_q, s1_inr_q, s1_byp_q;
  logic [DATA_WIDTH-1:0] s1_byp_data_q;
  logic                  hit1;
  logic [DATA_WIDTH-1:0] data1;

  // State register; busy/clear_done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      sweep_q      <= '0;
      busy_q       <= 1'b1;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      busy_q       <= (state_d == CLEAR);
      clear_done_q <= (state_d == CLEAR) && (sweep_d == LAST);
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          sweep_d = '0;
        end
      end
      CLEAR: begin
        if (sweep_q == LAST) state_d = IDLE;
        else                 sweep_d = sweep_q + ADDR_WIDTH'(1);
      end
    endcase
  end

  assign idle     = (state_q == IDLE);
  assign sweeping = (state_q == CLEAR);
  assign wr_acc   = idle & bus.wr_en & ({1'b0, bus.wr_addr} < DEPTH_X);
  assign rd_acc   = idle & bus.rd_en;
  assign rd_inr   = ({1'b0, bus.rd_addr} < DEPTH_X);
  assign byp      = wr_acc & rd_acc & (bus.wr_addr == bus.rd_addr);

  // The sweeper owns the valid column's write port while clearing.
  assign vld_we    = wr_acc | sweeping;
  assign vld_waddr = sweeping ? IW'(sweep_q) : IW'(bus.wr_addr);
  assign vld_wdata = ~sweeping;

  sdp_ram_core #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_W(IW)) u_data (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (IW'(bus.wr_addr)),
    .wdata (bus.wr_data),
    .re    (rd_acc & rd_inr),
    .raddr (IW'(bus.rd_addr)),
    .rdata (data_rdata)
  );

  sdp_ram_core #(.DEPTH(DEPTH), .DATA_WIDTH(1), .ADDR_W(IW)) u_valid (
    .clk   (clk),
    .we    (vld_we),
    .waddr (vld_waddr),
    .wdata (vld_wdata),
    .re    (rd_acc & rd_inr),
    .raddr (IW'(bus.rd_addr)),
    .rdata (vld_rdata)
  );

  // Read-side sideband travels alongside the RAM read; held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_inr_q      <= 1'b0;
      s1_byp_q      <= 1'b0;
      s1_byp_data_q <= '0;
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) begin
        s1_inr_q      <= rd_inr;
        s1_byp_q      <= byp;
        s1_byp_data_q <= bus.wr_data;
      end
    end
  end

  assign hit1  = s1_byp_q | (s1_inr_q & vld_rdata[0]);
  assign data1 = s1_byp_q ? s1_byp_data_q : (hit1 ? data_rdata : '0);

  assign bus.busy       = busy_q;
  assign bus.clear_done = clear_done_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic                  rd_valid_q, rd_hit_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Registered response, zeroed between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid_q <= 1'b0;
        rd_hit_q   <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        rd_valid_q <= s1_valid_q;
        rd_hit_q   <= s1_valid_q & hit1;
        rd_data_q  <= s1_valid_q ? data1 : '0;
      end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_hit   = rd_hit_q;
    assign bus.rd_data  = rd_data_q;
  end else begin : g_no_out_reg
    assign bus.rd_valid = s1_valid_q;
    assign bus.rd_hit   = hit1;
    assign bus.rd_data  = data1;
  end

endmodule

// File: tb/tb_lzw_dict_ram.sv
// Scoreboard bench for lzw_dict_ram: two instances (OUT_REG=0 and 1) share one stimulus stream.
module tb_lzw_dict_ram;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 20;
  localparam int unsigned DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lzw_dict_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  lzw_dict_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  lzw_dict_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  lzw_dict_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  typedef struct {
    int          due;
    logic        hit;
    logic [DW-1:0] data;
  } exp_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t          q [2][$];
  logic          last_h [2];
  logic [DW-1:0] last_d [2];

  // Reference model: what the table holds, and how many sweep cycles remain.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_vld [DEPTH];
  int            busy_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic mon(input int g, input logic v, input logic h, input logic [DW-1:0] d);
    exp_t e;
    if (!rst_n) begin
      last_h[g] = 1'b0;
      last_d[g] = '0;
      return;
    end
    if (v) begin
      if (q[g].size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rd_valid%0d: got 1 want 0 (cycle %0d)", g, cyc);
      end else begin
        e = q[g].pop_front();
        chk($sformatf("latency%0d", g), cyc, e.due);
        chk($sformatf("rd_hit%0d", g), h, e.hit);
        chk($sformatf("rd_data%0d", g), d, e.data);
        last_h[g] = e.hit;
        last_d[g] = e.data;
      end
    end else begin
      if (q[g].size() > 0 && q[g][0].due <= cyc) begin
        e = q[g].pop_front();
        total++; bad++;
        $display("FAIL missing_rd_valid%0d: got 0 want 1 (due cycle %0d)", g, e.due);
      end
      if (g == 1) chk("idle_zero1", {31'(0), h} | 32'(d), 32'(0));
      else        chk("hold0", {h, d}, {last_h[g], last_d[g]});
    end
  endtask

  always @(negedge clk) mon(0, bus0.rd_valid, bus0.rd_hit, bus0.rd_data);
  always @(negedge clk) mon(1, bus1.rd_valid, bus1.rd_hit, bus1.rd_data);

  task automatic drive(input bit wr, input int wa, input logic [DW-1:0] wd,
                       input bit rd, input int ra, input bit clr);
    bus0.wr_en = wr; bus0.wr_addr = AW'(wa); bus0.wr_data = wd;
    bus0.rd_en = rd; bus0.rd_addr = AW'(ra); bus0.clear_req = clr;
    bus1.wr_en = wr; bus1.wr_addr = AW'(wa); bus1.wr_data = wd;
    bus1.rd_en = rd; bus1.rd_addr = AW'(ra); bus1.clear_req = clr;
  endtask

  // One clock: check status, present inputs, advance the model, move to next negedge.
  task automatic step(input bit wr, input int wa, input logic [DW-1:0] wd,
                      input bit rd, input int ra, input bit clr);
    exp_t e;
    chk("busy0", bus0.busy, busy_left > 0);
    chk("busy1", bus1.busy, busy_left > 0);
    chk("clear_done0", bus0.clear_done, busy_left == 1);
    chk("clear_done1", bus1.clear_done, busy_left == 1);
    drive(wr, wa, wd, rd, ra, clr);
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (rd) begin
        if (wr && wa < DEPTH && wa == ra) begin
          e.hit = 1'b1; e.data = wd;
        end else if (ra < DEPTH && m_vld[ra]) begin
          e.hit = 1'b1; e.data = m_mem[ra];
        end else begin
          e.hit = 1'b0; e.data = '0;
        end
        e.due = cyc + 1; q[0].push_back(e);
        e.due = cyc + 2; q[1].push_back(e);
      end
      if (wr && wa < DEPTH) begin
        m_mem[wa] = wd;
        m_vld[wa] = 1'b1;
      end
      if (clr) begin
        foreach (m_vld[i]) m_vld[i] = 1'b0;
        busy_left = DEPTH;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    drive(1'b0, 0, '0, 1'b0, 0, 1'b0);
    q[0].delete();
    q[1].delete();
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    busy_left = DEPTH;
    foreach (m_vld[i]) m_vld[i] = 1'b0;
  endtask

  // Runs until busy drops (bounded), optionally with ignored port traffic; checks sweep length.
  task automatic sweep_run(input bit noisy);
    int nb = 0;
    int nd = 0;
    int guard = 0;
    while (bus0.busy && guard < 4 * DEPTH) begin
      nb += int'(bus0.busy);
      nd += int'(bus0.clear_done);
      guard++;
      if (noisy) step(1'b1, $urandom_range(0, 15), DW'($urandom), 1'b1, $urandom_range(0, 15), 1'b1);
      else       idle_step();
    end
    chk("sweep_len", nb, DEPTH);
    chk("clear_done_cnt", nd, 1);
  endtask

  initial begin
    drive(1'b0, 0, '0, 1'b0, 0, 1'b0);
    do_reset(3);
    // Reset sweep, then a read of a cleared entry.
    sweep_run(1'b0);
    step(1'b0, 0, '0, 1'b1, 5, 1'b0);
    idle_step();

    // Write then read; then same-cycle write/read bypass.
    step(1'b1, 3, 20'h12345, 1'b0, 0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 3, 1'b0);
    step(1'b1, 7, 20'h00ABC, 1'b1, 7, 1'b0);
    repeat (3) idle_step();

    // Fill, clear together with a write, reads ignored while busy, then all invalid.
    for (int a = 0; a < int'(DEPTH); a++) step(1'b1, a, DW'($urandom), 1'b0, 0, 1'b0);
    step(1'b1, 2, 20'h55555, 1'b1, 2, 1'b1);
    sweep_run(1'b1);
    for (int a = 0; a < int'(DEPTH); a++) step(1'b0, 0, '0, 1'b1, a, 1'b0);
    repeat (3) idle_step();

    // Reset mid-sweep at address 9 restarts the full sweep.
    for (int a = 0; a < 6; a++) step(1'b1, a, DW'($urandom), 1'b0, 0, 1'b0);
    repeat (2) idle_step();
    step(1'b0, 0, '0, 1'b0, 0, 1'b1);
    for (int g = 0; g < 40 && busy_left > int'(DEPTH) - 9; g++) idle_step();
    do_reset(2);
    sweep_run(1'b0);
    for (int a = 0; a < 6; a++) step(1'b0, 0, '0, 1'b1, a, 1'b0);

    // Back-to-back reads in order; out-of-range write dropped.
    for (int a = 0; a < int'(DEPTH); a++) step(1'b1, a, DW'($urandom), 1'b0, 0, 1'b0);
    for (int a = 0; a < int'(DEPTH); a++) step(1'b0, 0, '0, 1'b1, a, 1'b0);
    step(1'b1, 20, 20'hFACE1, 1'b0, 0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 20, 1'b0);
    step(1'b1, 20, 20'hFACE2, 1'b1, 20, 1'b0);
    step(1'b0, 0, '0, 1'b1, 4, 1'b0);
    repeat (3) idle_step();

    // Randomised traffic including occasional clears.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 21), DW'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 21), $urandom_range(0, 79) == 0);
    for (int g = 0; g < 40 && busy_left > 0; g++) idle_step();
    repeat (4) idle_step();

    chk("q0_drained", q[0].size(), 0);
    chk("q1_drained", q[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
